// File: rtl/vfu_mask_dispatch.sv
// vfu_mask_dispatch: routes vid-tagged mask words into per-FU FIFOs, one FIFO per functional unit
module vfu_mask_dispatch #(
   parameter int unsigned NrFUs         = 2,
   parameter int unsigned StrbWidth     = 8,
   parameter int unsigned VidWidth      = 3,
   parameter int unsigned FifoDepth     = 2,
   parameter int unsigned TimeoutCycles = 16
) (
   input  logic                           clk_i,
   input  logic                           rst_i,
   input  logic [StrbWidth-1:0]           mask_i,
   input  logic [VidWidth-1:0]            mask_vid_i,
   input  logic                           mask_valid_i,
   output logic                           mask_ready_o,
   input  logic [NrFUs-1:0]               fu_active_i,
   input  logic [NrFUs*VidWidth-1:0]      fu_vid_i,
   output logic [NrFUs*StrbWidth-1:0]     fu_mask_o,
   output logic [NrFUs-1:0]               fu_mask_valid_o,
   input  logic [NrFUs-1:0]               fu_mask_ready_i,
   output logic [NrFUs-1:0]               fifo_full_o,
   output logic                           conflict_o,
   output logic                           unmatched_o
);
   localparam int unsigned PtrW = $clog2(FifoDepth);
   localparam int unsigned WaitW = $clog2(TimeoutCycles + 1);
   localparam int unsigned TgtW = NrFUs > 1 ? $clog2(NrFUs) : 1;
   localparam int unsigned HitW = $clog2(NrFUs + 1);
   localparam logic [PtrW:0] FullCnt = (PtrW+1)'(FifoDepth);
   localparam logic [WaitW-1:0] WaitMax = WaitW'(TimeoutCycles);

   logic [StrbWidth-1:0] mem_q [NrFUs][FifoDepth];
   logic [PtrW-1:0]      rptr_q [NrFUs];
   logic [PtrW-1:0]      wptr_q [NrFUs];
   logic [PtrW:0]        cnt_q [NrFUs];
   logic [PtrW:0]        cnt_d [NrFUs];
   logic [WaitW-1:0]     wait_q, wait_d;
   logic                 conflict_q, unmatched_q;
   logic [NrFUs-1:0]     match, enq, deq;
   logic [TgtW-1:0]      target;
   logic [HitW-1:0]      hits;

   // Descending scan so the lowest matching index wins the routing
   always_comb begin
      match = '0;
      target = '0;
      hits = '0;
      for (int k = NrFUs - 1; k >= 0; k--) begin
         match[k] = fu_active_i[k] && fu_vid_i[k*VidWidth +: VidWidth] == mask_vid_i;
         if (match[k]) target = TgtW'(k);
         hits = hits + HitW'(match[k]);
      end
   end

   assign mask_ready_o = mask_valid_i && |match && !fifo_full_o[target];

   always_comb begin
      enq = '0;
      deq = '0;
      fu_mask_o = '0;
      fu_mask_valid_o = '0;
      fifo_full_o = '0;
      for (int k = 0; k < NrFUs; k++) begin
         fu_mask_valid_o[k] = cnt_q[k] != '0;
         fifo_full_o[k] = cnt_q[k] == FullCnt;
         fu_mask_o[k*StrbWidth +: StrbWidth] = fu_mask_valid_o[k] ? mem_q[k][rptr_q[k]] : '0;
         enq[k] = mask_ready_o && target == TgtW'(k);
         deq[k] = fu_mask_valid_o[k] && fu_mask_ready_i[k];
         cnt_d[k] = cnt_q[k] + (PtrW+1)'(enq[k]) - (PtrW+1)'(deq[k]);
      end
      wait_d = (mask_valid_i && !(|match)) ? (wait_q == WaitMax ? wait_q : wait_q + 1'b1) : '0;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int k = 0; k < NrFUs; k++) begin
            rptr_q[k] <= '0;
            wptr_q[k] <= '0;
            cnt_q[k] <= '0;
         end
         wait_q <= '0;
         conflict_q <= 1'b0;
         unmatched_q <= 1'b0;
      end else begin
         for (int k = 0; k < NrFUs; k++) begin
            if (enq[k]) mem_q[k][wptr_q[k]] <= mask_i;
            if (enq[k]) wptr_q[k] <= wptr_q[k] + 1'b1;
            if (deq[k]) rptr_q[k] <= rptr_q[k] + 1'b1;
            cnt_q[k] <= cnt_d[k];
         end
         wait_q <= wait_d;
         conflict_q <= conflict_q | (mask_valid_i && hits > HitW'(1));
         unmatched_q <= unmatched_q | (wait_d == WaitMax);
      end
   end

   assign conflict_o = conflict_q;
   assign unmatched_o = unmatched_q;

`ifndef SYNTHESIS
   a_stable: assert property (@(posedge clk_i) disable iff (rst_i)
      (mask_valid_i && !mask_ready_o) |=> (!mask_valid_i || ($stable(mask_i) && $stable(mask_vid_i))));
`endif
endmodule

// File: tb/tb_vfu_mask_dispatch.sv
// tb_vfu_mask_dispatch: scoreboard bench with per-FU expected-word queues and sticky-flag model
module tb_vfu_mask_dispatch;
   localparam int N = 2;
   localparam int D = 2;
   localparam int TO = 16;

   logic clk = 1'b0;
   logic rst;
   logic [7:0] mdata;
   logic [2:0] mvid;
   logic mvalid;
   logic mready;
   logic [1:0] act;
   logic [2:0] fvid [2];
   logic [15:0] fmask;
   logic [1:0] fvalid, frdy, ffull;
   logic conflict, unmatched;

   logic [7:0] q [2][$];
   logic conf_m, unm_m, last_acc;
   int wcnt, n_chk, n_pass;

   always #5 clk = ~clk;

   vfu_mask_dispatch dut (
      .clk_i(clk), .rst_i(rst), .mask_i(mdata), .mask_vid_i(mvid), .mask_valid_i(mvalid),
      .mask_ready_o(mready), .fu_active_i(act), .fu_vid_i({fvid[1], fvid[0]}),
      .fu_mask_o(fmask), .fu_mask_valid_o(fvalid), .fu_mask_ready_i(frdy),
      .fifo_full_o(ffull), .conflict_o(conflict), .unmatched_o(unmatched)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic cycle();
      int t, h;
      logic rdy;
      #1;
      t = -1;
      h = 0;
      rdy = 1'b0;
      for (int k = N - 1; k >= 0; k--)
         if (act[k] && fvid[k] == mvid) begin
            t = k;
            h++;
         end
      if (mvalid && t >= 0) rdy = q[t].size() < D;
      for (int k = 0; k < N; k++) begin
         chk($sformatf("valid%0d", k), fvalid[k], q[k].size() != 0);
         chk($sformatf("data%0d", k), fmask[k*8 +: 8], q[k].size() != 0 ? q[k][0] : 8'h00);
         chk($sformatf("full%0d", k), ffull[k], q[k].size() == D);
      end
      chk("ready", mready, rdy);
      chk("conflict", conflict, conf_m);
      chk("unmatched", unmatched, unm_m);
      @(posedge clk);
      if (rst) begin
         for (int k = 0; k < N; k++) q[k].delete();
         conf_m = 1'b0;
         unm_m = 1'b0;
         wcnt = 0;
      end else begin
         for (int k = 0; k < N; k++)
            if (q[k].size() != 0 && frdy[k]) void'(q[k].pop_front());
         if (rdy) q[t].push_back(mdata);
         if (mvalid && h > 1) conf_m = 1'b1;
         wcnt = (mvalid && t < 0) ? (wcnt < TO ? wcnt + 1 : TO) : 0;
         if (wcnt == TO) unm_m = 1'b1;
      end
      last_acc = rdy;
      @(negedge clk);
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic send(input logic [7:0] d, input logic [2:0] v);
      mdata = d;
      mvid = v;
      mvalid = 1'b1;
      cycle();
   endtask

   initial begin
      n_chk = 0; n_pass = 0; wcnt = 0;
      conf_m = 1'b0; unm_m = 1'b0; last_acc = 1'b0;
      rst = 1'b1; mdata = '0; mvid = '0; mvalid = 1'b0;
      act = '0; fvid[0] = '0; fvid[1] = '0; frdy = '0;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      run(1);
      // 1: single word to FU1
      act = 2'b11; fvid[0] = 3'd3; fvid[1] = 3'd5;
      send(8'hA5, 3'd5);
      mvalid = 1'b0;
      cycle();
      frdy = 2'b10;
      cycle();
      frdy = 2'b00;
      // 2: FU0 fills, third word stalls until one dequeue
      act = 2'b01; fvid[0] = 3'd2;
      send(8'h01, 3'd2);
      send(8'h02, 3'd2);
      send(8'h03, 3'd2);
      cycle();
      frdy = 2'b01;
      cycle();
      frdy = 2'b00;
      cycle();
      mvalid = 1'b0;
      cycle();
      // 3: FU1 unaffected by full FU0
      act = 2'b11; fvid[1] = 3'd4;
      send(8'h77, 3'd4);
      mvalid = 1'b0;
      cycle();
      frdy = 2'b10;
      cycle();
      frdy = 2'b01;
      run(2);
      frdy = 2'b00;
      // 4: duplicate vid routes to FU0 and raises conflict
      fvid[0] = 3'd1; fvid[1] = 3'd1;
      send(8'h0F, 3'd1);
      mvalid = 1'b0;
      run(3);
      frdy = 2'b01;
      cycle();
      frdy = 2'b00;
      // 5: unmatched timeout, then drain after deactivation
      act = 2'b01; fvid[0] = 3'd6; fvid[1] = 3'd0;
      send(8'h11, 3'd6);
      send(8'h22, 3'd6);
      mdata = 8'h99; mvid = 3'd7; mvalid = 1'b1;
      run(17);
      act = 2'b00; frdy = 2'b01;
      run(3);
      mvalid = 1'b0; frdy = 2'b00;
      cycle();
      // 6: reset mid-stream
      act = 2'b11; fvid[0] = 3'd1; fvid[1] = 3'd2;
      send(8'h31, 3'd1);
      send(8'h32, 3'd2);
      mvalid = 1'b0;
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      cycle();
      send(8'h44, 3'd1);
      mvalid = 1'b0;
      cycle();
      frdy = 2'b11;
      cycle();
      // random traffic, holding a stalled word stable
      for (int i = 0; i < 300; i++) begin
         if (!(mvalid && !last_acc)) begin
            mvalid = $urandom_range(0, 1) == 1;
            mdata = 8'($urandom);
            mvid = 3'($urandom_range(0, 3));
         end
         act = 2'($urandom);
         fvid[0] = 3'($urandom_range(0, 3));
         fvid[1] = 3'($urandom_range(0, 3));
         frdy = 2'($urandom);
         cycle();
      end
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
